// File: rtl/execute_stage.sv
// Execute stage of the Mini-RISC-V pipeline: single-cycle RV32I ALU plus an
// iterative RV32M multiply/divide unit that stalls upstream while it runs.
module execute_stage #(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            Rst,
   input  logic            debug,
   input  logic [XLEN-1:0] ID_EX_op1,
   input  logic [XLEN-1:0] ID_EX_op2,
   input  logic [XLEN-1:0] ID_EX_rs2val,
   input  logic [3:0]      ID_EX_aluop,
   input  logic            ID_EX_md,
   input  logic [2:0]      ID_EX_mdfunct3,
   input  logic [2:0]      ID_EX_storecntrl,
   input  logic [4:0]      ID_EX_loadcntrl,
   input  logic [4:0]      ID_EX_rd,
   input  logic            ID_EX_regwrite,
   input  logic            ID_EX_memread,
   input  logic            ID_EX_memwrite,
   output logic            EX_stall,
   output logic [XLEN-1:0] EX_MEM_alures,
   output logic [XLEN-1:0] EX_MEM_alusec,
   output logic [2:0]      EX_MEM_storecntrl,
   output logic [4:0]      EX_MEM_loadcntrl,
   output logic [4:0]      EX_MEM_rd,
   output logic            EX_MEM_regwrite,
   output logic            EX_MEM_memread,
   output logic            EX_MEM_memwrite
);

   localparam int CNT_W = $clog2(MD_ITER + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_ITER - 1);
   localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } md_state_t;

   typedef struct packed {
      logic [XLEN-1:0] alures;
      logic [XLEN-1:0] alusec;
      logic [2:0]      storecntrl;
      logic [4:0]      loadcntrl;
      logic [4:0]      rd;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
   } ex_mem_t;

   md_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] op1_q, op2_q;
   logic [XLEN-1:0] mag_a_q, mag_b_q;
   logic            neg_a_q, neg_b_q;
   logic [XLEN-1:0] acc_hi_q, acc_lo_q;
   ex_mem_t         ex_mem_q;

   logic [XLEN-1:0]   alu_res;
   logic [4:0]        shamt;
   logic              signed_a, signed_b;
   logic              neg_a_d, neg_b_d;
   logic [XLEN-1:0]   mag_a_d, mag_b_d;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   md_res;
   ex_mem_t           ex_mem_d;

   // Base RV32I operations.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      alu_res = '0;
      shamt   = ID_EX_op2[4:0];
      case (ID_EX_aluop)
         4'd0:  alu_res = ID_EX_op1 + ID_EX_op2;
         4'd1:  alu_res = ID_EX_op1 - ID_EX_op2;
         4'd2:  alu_res = ID_EX_op1 << shamt;
         4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(ID_EX_op1) < $signed(ID_EX_op2)};
         4'd4:  alu_res = {{(XLEN-1){1'b0}}, ID_EX_op1 < ID_EX_op2};
         4'd5:  alu_res = ID_EX_op1 ^ ID_EX_op2;
         4'd6:  alu_res = ID_EX_op1 >> shamt;
         4'd7:  alu_res = $signed(ID_EX_op1) >>> shamt;
         4'd8:  alu_res = ID_EX_op1 | ID_EX_op2;
         4'd9:  alu_res = ID_EX_op1 & ID_EX_op2;
         4'd10: alu_res = ID_EX_op2;
         default: alu_res = '0;
      endcase
   end

   // Operand signedness: MUL/MULH/DIV/REM signed both, MULHSU signed op1 only.
   always_comb begin
      signed_a = (ID_EX_mdfunct3 != 3'd3) && (ID_EX_mdfunct3 != 3'd5) && (ID_EX_mdfunct3 != 3'd7);
      signed_b = (ID_EX_mdfunct3 == 3'd0) || (ID_EX_mdfunct3 == 3'd1) ||
                 (ID_EX_mdfunct3 == 3'd4) || (ID_EX_mdfunct3 == 3'd6);
      neg_a_d  = signed_a && ID_EX_op1[XLEN-1];
      neg_b_d  = signed_b && ID_EX_op2[XLEN-1];
      mag_a_d  = neg_a_d ? -ID_EX_op1 : ID_EX_op1;
      mag_b_d  = neg_b_d ? -ID_EX_op2 : ID_EX_op2;
   end

   // One shift-add / restoring-subtract step on the magnitudes.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, mag_b_q};
   end

   // Sign fixup and result selection, used in DONE.
   always_comb begin
      prod_s   = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
      quo_s    = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
      rem_s    = neg_a_q ? -acc_hi_q : acc_hi_q;
      div_zero = (op2_q == '0);
      div_ovf  = !f3_q[0] && (op1_q == INT_MIN) && (op2_q == '1);
      md_res   = '0;
      case (f3_q)
         3'd0:         md_res = prod_s[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:         md_res = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:   md_res = div_zero ? '1 : (div_ovf ? INT_MIN : quo_s);
         default:      md_res = div_zero ? op1_q : (div_ovf ? '0 : rem_s);
      endcase
   end

   always_comb begin
      ex_mem_d            = '0;
      ex_mem_d.alures     = (state_q == DONE) ? md_res : alu_res;
      ex_mem_d.alusec     = ID_EX_rs2val;
      ex_mem_d.storecntrl = ID_EX_storecntrl;
      ex_mem_d.loadcntrl  = ID_EX_loadcntrl;
      ex_mem_d.rd         = ID_EX_rd;
      ex_mem_d.regwrite   = ID_EX_regwrite;
      ex_mem_d.memread    = ID_EX_memread;
      ex_mem_d.memwrite   = ID_EX_memwrite;
   end

   // FSM, M-unit datapath and EX/MEM register; debug freezes all of it.
   always_ff @(posedge clk or posedge Rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (Rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         ex_mem_q <= '0;
      end else if (!debug) begin
         case (state_q)
            IDLE: begin
               if (ID_EX_md) begin
                  state_q  <= BUSY;
                  cnt_q    <= '0;
                  f3_q     <= ID_EX_mdfunct3;
                  op1_q    <= ID_EX_op1;
                  op2_q    <= ID_EX_op2;
                  mag_a_q  <= mag_a_d;
                  mag_b_q  <= mag_b_d;
                  neg_a_q  <= neg_a_d;
                  neg_b_q  <= neg_b_d;
                  acc_hi_q <= '0;
                  acc_lo_q <= ID_EX_mdfunct3[2] ? mag_a_d : mag_b_d;
                  ex_mem_q <= '0;
               end else begin
                  ex_mem_q <= ex_mem_d;
               end
            end
            BUSY: begin
               if (f3_q[2]) begin
                  acc_hi_q <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                  acc_lo_q <= {acc_lo_q[XLEN-2:0], ~div_diff[XLEN]};
               end else begin
                  {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[XLEN-1:1]};
               end
               cnt_q    <= cnt_q + 1'b1;
               ex_mem_q <= '0;
               if (cnt_q == LAST_STEP) state_q <= DONE;
            end
            DONE: begin
               ex_mem_q <= ex_mem_d;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall is gated by Rst so it reads 0 the moment reset is applied.
   assign EX_stall = !Rst && (((state_q == IDLE) && ID_EX_md && !debug) || (state_q == BUSY));

   assign EX_MEM_alures     = ex_mem_q.alures;
   assign EX_MEM_alusec     = ex_mem_q.alusec;
   assign EX_MEM_storecntrl = ex_mem_q.storecntrl;
   assign EX_MEM_loadcntrl  = ex_mem_q.loadcntrl;
   assign EX_MEM_rd         = ex_mem_q.rd;
   assign EX_MEM_regwrite   = ex_mem_q.regwrite;
   assign EX_MEM_memread    = ex_mem_q.memread;
   assign EX_MEM_memwrite   = ex_mem_q.memwrite;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected EX/MEM contents are queued at
// issue and compared when the stage writes back a result.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        Rst;
   logic        debug;
   logic [31:0] ID_EX_op1, ID_EX_op2, ID_EX_rs2val;
   logic [3:0]  ID_EX_aluop;
   logic        ID_EX_md;
   logic [2:0]  ID_EX_mdfunct3;
   logic [2:0]  ID_EX_storecntrl;
   logic [4:0]  ID_EX_loadcntrl;
   logic [4:0]  ID_EX_rd;
   logic        ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite;
   logic        EX_stall;
   logic [31:0] EX_MEM_alures, EX_MEM_alusec;
   logic [2:0]  EX_MEM_storecntrl;
   logic [4:0]  EX_MEM_loadcntrl;
   logic [4:0]  EX_MEM_rd;
   logic        EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memwrite;

   execute_stage dut (
      .clk               (clk),
      .Rst               (Rst),
      .debug             (debug),
      .ID_EX_op1         (ID_EX_op1),
      .ID_EX_op2         (ID_EX_op2),
      .ID_EX_rs2val      (ID_EX_rs2val),
      .ID_EX_aluop       (ID_EX_aluop),
      .ID_EX_md          (ID_EX_md),
      .ID_EX_mdfunct3    (ID_EX_mdfunct3),
      .ID_EX_storecntrl  (ID_EX_storecntrl),
      .ID_EX_loadcntrl   (ID_EX_loadcntrl),
      .ID_EX_rd          (ID_EX_rd),
      .ID_EX_regwrite    (ID_EX_regwrite),
      .ID_EX_memread     (ID_EX_memread),
      .ID_EX_memwrite    (ID_EX_memwrite),
      .EX_stall          (EX_stall),
      .EX_MEM_alures     (EX_MEM_alures),
      .EX_MEM_alusec     (EX_MEM_alusec),
      .EX_MEM_storecntrl (EX_MEM_storecntrl),
      .EX_MEM_loadcntrl  (EX_MEM_loadcntrl),
      .EX_MEM_rd         (EX_MEM_rd),
      .EX_MEM_regwrite   (EX_MEM_regwrite),
      .EX_MEM_memread    (EX_MEM_memread),
      .EX_MEM_memwrite   (EX_MEM_memwrite)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] sec;
      logic [14:0] ctl;
      int          lat;
      int          stalls;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   op_idx = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << b[4:0];
         4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> b[4:0];
         4'd7:  return 32'($signed(a) >>> b[4:0]);
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb64, ua, ub, p;
      logic        ovf;
      sa   = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb64; return p[31:0]; end
         3'd1: begin p = sa * sb64; return p[63:32]; end
         3'd2: begin p = sa * ub;   return p[63:32]; end
         3'd3: begin p = ua * ub;   return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one instruction at a negedge, then run until its write-back
   // appears (bounded), optionally freezing with debug partway through.
   task automatic run_op(input string tag, input logic md, input logic [2:0] f3,
                         input logic [3:0] aluop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int dbg_start, input int dbg_len);
      exp_t e;
      int   stalls;
      int   lat;
      logic got;
      logic bub_bad;
      op_idx++;
      ID_EX_op1        = a;
      ID_EX_op2        = b;
      ID_EX_aluop      = aluop;
      ID_EX_md         = md;
      ID_EX_mdfunct3   = f3;
      ID_EX_rs2val     = $urandom;
      ID_EX_rd         = 5'(op_idx % 31 + 1);
      ID_EX_storecntrl = 3'(op_idx);
      ID_EX_loadcntrl  = 5'(op_idx * 3);
      ID_EX_memread    = op_idx[0];
      ID_EX_memwrite   = op_idx[1];
      ID_EX_regwrite   = 1'b1;
      e.res    = exp_res;
      e.sec    = ID_EX_rs2val;
      e.ctl    = {ID_EX_rd, ID_EX_storecntrl, ID_EX_loadcntrl, ID_EX_memread, ID_EX_memwrite};
      e.lat    = md ? 34 + dbg_len : 1;
      e.stalls = md ? 33 + dbg_len : 0;
      sb.push_back(e);
      got = 1'b0; bub_bad = 1'b0; stalls = 0; lat = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         debug = (dbg_len > 0) && (c >= dbg_start) && (c < dbg_start + dbg_len);
         #1;
         if (EX_stall) stalls++;
         @(negedge clk);
         lat = c + 1;
         if (EX_MEM_regwrite)
            got = 1'b1;
         else if (EX_MEM_alures !== 0 || EX_MEM_alusec !== 0 || EX_MEM_rd !== 0 ||
                  EX_MEM_storecntrl !== 0 || EX_MEM_loadcntrl !== 0 ||
                  EX_MEM_memread !== 0 || EX_MEM_memwrite !== 0)
            bub_bad = 1'b1;
      end
      debug = 1'b0;
      check({tag, "/writeback_seen"}, 64'(got), 64'd1);
      check({tag, "/bubble_clean"}, 64'(bub_bad), 64'd0);
      if (got && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "/alures"}, 64'(EX_MEM_alures), 64'(e.res));
         check({tag, "/alusec"}, 64'(EX_MEM_alusec), 64'(e.sec));
         check({tag, "/ctl"}, 64'({EX_MEM_rd, EX_MEM_storecntrl, EX_MEM_loadcntrl,
                                    EX_MEM_memread, EX_MEM_memwrite}), 64'(e.ctl));
         check({tag, "/latency"}, 64'(lat), 64'(e.lat));
         check({tag, "/stall_cycles"}, 64'(stalls), 64'(e.stalls));
      end else begin
         void'(sb.pop_front());
      end
   endtask

   logic [31:0] ra, rb;
   logic [2:0]  rf;

   initial begin
      Rst = 1'b1; debug = 1'b0;
      ID_EX_op1 = '0; ID_EX_op2 = '0; ID_EX_rs2val = '0; ID_EX_aluop = '0;
      ID_EX_md = 1'b0; ID_EX_mdfunct3 = '0; ID_EX_storecntrl = '0; ID_EX_loadcntrl = '0;
      ID_EX_rd = '0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0; ID_EX_memwrite = 1'b0;
      #1;
      check("reset/stall", 64'(EX_stall), 64'd0);
      check("reset/outputs", 64'({EX_MEM_alures, EX_MEM_rd, EX_MEM_regwrite, EX_MEM_memread,
                                    EX_MEM_memwrite, EX_MEM_storecntrl, EX_MEM_loadcntrl}), 64'd0);
      check("reset/alusec", 64'(EX_MEM_alusec), 64'd0);
      repeat (2) @(negedge clk);
      Rst = 1'b0;

      run_op("add", 1'b0, 3'd0, 4'd0, 32'd5, 32'hFFFF_FFFD, 32'd2, 0, 0);
      run_op("sra", 1'b0, 3'd0, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0);
      run_op("slt_neg", 1'b0, 3'd0, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
      run_op("sltu_neg", 1'b0, 3'd0, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
      for (int op = 0; op < 16; op++) begin
         ra = $urandom; rb = $urandom;
         run_op($sformatf("alu%0d", op), 1'b0, 3'd0, 4'(op), ra, rb, ref_alu(4'(op), ra, rb), 0, 0);
      end

      run_op("mul", 1'b1, 3'd0, 4'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 0, 0);
      run_op("mulhu", 1'b1, 3'd3, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
      run_op("mulh", 1'b1, 3'd1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0);
      run_op("mulhsu", 1'b1, 3'd2, 4'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 0);
      run_op("div", 1'b1, 3'd4, 4'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0);
      run_op("rem", 1'b1, 3'd6, 4'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0);
      run_op("div_by0", 1'b1, 3'd4, 4'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
      run_op("remu_by0", 1'b1, 3'd7, 4'd0, 32'd5, 32'd0, 32'd5, 0, 0);
      run_op("div_ovf", 1'b1, 3'd4, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
      run_op("rem_ovf", 1'b1, 3'd6, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0);
      run_op("mul_debug", 1'b1, 3'd0, 4'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 10, 5);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom; rb = $urandom; rf = 3'(i);
         if (i >= 4) rb = rb >> (i * 3);
         run_op($sformatf("md_rand%0d", i), 1'b1, rf, 4'd0, ra, rb, ref_md(rf, ra, rb), 0, 0);
      end
      run_op("add_after_md", 1'b0, 3'd0, 4'd0, 32'd7, 32'd8, 32'd15, 0, 0);

      // Abort an in-flight MUL with an asynchronous reset between edges.
      ID_EX_op1 = 32'h1234_5678; ID_EX_op2 = 32'h10; ID_EX_md = 1'b1;
      ID_EX_mdfunct3 = 3'd0; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd9;
      repeat (10) @(negedge clk);
      #1;
      check("rst_abort/stall_before", 64'(EX_stall), 64'd1);
      #2;
      Rst = 1'b1;
      ID_EX_md = 1'b0;
      #1;
      check("rst_abort/stall", 64'(EX_stall), 64'd0);
      check("rst_abort/outputs", 64'({EX_MEM_alures, EX_MEM_rd, EX_MEM_regwrite, EX_MEM_memread,
                                       EX_MEM_memwrite, EX_MEM_storecntrl, EX_MEM_loadcntrl}), 64'd0);
      @(negedge clk);
      Rst = 1'b0;
      run_op("add_after_rst", 1'b0, 3'd0, 4'd0, 32'd1, 32'd1, 32'd2, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
